ac_unit: RTL and testbench
==========================

Name: ac_unit

Overview:
- Accumulator unit for the basic-computer datapath. It merges AC control decode with the AC and E registers it drives.
- Parametrised in word width and input-port width.
- Executes the memory-reference AC ops at T5 and the register-reference and I/O AC ops at T3.
- Produces the skip condition and the FGI-clear strobe for the sequencer.

Parameters:
- WORD_W, 16, width of AC, DR and the bus path.
- IN_W, 8, width of INPR; legal range is 1 <= IN_W <= WORD_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- dec_t  in  8  one-hot timing decoder outputs T0..T7
- dec_d  in  8  one-hot opcode decoder outputs D0..D7
- iff_data  in  1  indirect bit I from the I flip-flop
- ir_data  in  12  IR address/micro-op field B0..B11
- dr_data  in  WORD_W  DR contents
- inpr_data  in  IN_W  input register
- ac_q  out  WORD_W  accumulator
- e_q  out  1  carry/extend flip-flop
- skip  out  1  combinational skip request (PC increment) for the current cycle
- fgi_clr  out  1  combinational FGI clear strobe
- ac_ovf  out  1  signed-overflow flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): ac_q=0, e_q=0, ac_ovf=0, independent of clk. skip and fgi_clr are combinational and read 0 when dec_t is all-zero.
- Qualifiers: r = D7 & ~I & T3; p = D7 & I & T3. The memory-reference strobe is D0/D1/D2 & T5.
- All register updates occur at posedge clk. ac_q and e_q reflect an operation one cycle after its qualifying cycle.
- Memory-reference ops:
  - AND (D0T5): ac <= ac & dr.
  - ADD (D1T5): {e, ac} <= ac + dr, an unsigned WORD_W+1-bit sum whose carry-out goes to E.
  - LDA (D2T5): ac <= dr.
- Register-reference ops, when r is high:
  - CLA B11: ac <= 0.
  - CLE B10: e <= 0.
  - CMA B9: ac <= ~ac.
  - CME B8: e <= ~e.
  - CIR B7: {ac, e} <= {e, ac} rotated right by 1, i.e. e <= ac[0], ac <= {e, ac[WORD_W-1:1]}.
  - CIL B6: e <= ac[WORD_W-1], ac <= {ac[WORD_W-2:0], e}.
  - INC B5: ac <= ac + 1, wrapping modulo 2^WORD_W; E unchanged.
- Skip tests, when r is high (read current ac/e, no register change):
  - SPA B4: skip = ~ac[MSB].
  - SNA B3: skip = ac[MSB].
  - SZA B2: skip = (ac == 0).
  - SZE B1: skip = ~e.
  - skip is the OR of all enabled tests.
- I/O (p high):
  - INP B11: ac[IN_W-1:0] <= inpr; upper bits are unchanged; fgi_clr = 1.
  - All other p bits leave AC and E untouched.
- Multiple IR bits set under r:
  - AC priority: CLA > CMA > CIR > CIL > INC.
  - E priority: CLE > CME, then the CIR/CIL rotate write.
  - When both CLE/CME and a rotate are set, CLE/CME wins on E; AC still takes the rotate result.
  - Skip tests are always evaluated and never blocked by other bits.
- No qualifying strobe: AC and E hold.
- Illegal strobe overlap (e.g. D1T5 together with r) cannot occur with one-hot decoders. Memory-reference ops take priority and r/p are ignored.
- Reset asserted mid-instruction aborts the operation; there is no partial write after release.

Optional Feature:
- Macro: AC_OVF_EN.
- Defined:
  - ac_ovf is a register set on ADD when operands share a sign and the result sign differs.
  - It is cleared by CLA, by LDA, and by reset.
  - It holds otherwise; AND, INC and INP do not affect it.
- Undefined: ac_ovf is tied to 0 and no register is inferred.

Decomposition:
- Shared package ac_pkg holds:
  - IR bit-position constants: B_CLA=11, B_CLE=10, B_CMA=9, B_CME=8, B_CIR=7, B_CIL=6, B_INC=5, B_SPA=4, B_SNA=3, B_SZA=2, B_SZE=1, B_INP=11.
  - Decoder index constants: D_AND=0, D_ADD=1, D_LDA=2, D_IO=7, T_EXE=3, T_MEM=5.
  - The AC op-select enum: NOP, AND, ADD, LDA, CLR, CMP, SHR, SHL, INC, INP.
- One sub-module ac_ctrl: purely combinational decode producing the op-select, the E op, skip and fgi_clr.
- The top level holds the AC/E/ovf registers and the ALU.

Test Plan (WORD_W=16, IN_W=8):
- Reset: assert rst asynchronously mid-cycle with ac=0x1234 -> ac_q=0, e_q=0 immediately, without waiting for a clk edge.
- ADD with carry: ac=0xFFFF, dr=0x0001, D1T5 -> next cycle ac_q=0x0000, e_q=1. With AC_OVF_EN, the pair ac=0x7FFF, dr=0x0001 -> ac_ovf=1.
- Rotates: ac=0x8001, e=0, CIL -> ac_q=0x0002, e_q=1. Then CIR -> ac_q=0x8001, e_q=0.
- INC wrap and skip: ac=0xFFFF, INC -> ac_q=0x0000, e_q unchanged. Then SZA under r -> skip=1 in that T3 cycle.
- INP: ac=0xAB00, inpr=0x5C, p with B11 -> ac_q=0xAB5C, fgi_clr=1 in the strobe cycle.
- Combined micro-ops: ac=0x00F0, e=1, ir bits CLE+CMA -> ac_q=0xFF0F, e_q=0. With no strobe for 3 cycles -> values hold.

Source files
------------

// File: rtl/ac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ac_pkg
// Purpose  : Shared constants and op-select types for the accumulator unit.
// Revision : 1.0  initial release
// ============================================================================
package ac_pkg;

  // IR bit positions (register-reference and I/O micro-ops)
  localparam int B_CLA = 11;
  localparam int B_CLE = 10;
  localparam int B_CMA = 9;
  localparam int B_CME = 8;
  localparam int B_CIR = 7;
  localparam int B_CIL = 6;
  localparam int B_INC = 5;
  localparam int B_SPA = 4;
  localparam int B_SNA = 3;
  localparam int B_SZA = 2;
  localparam int B_SZE = 1;
  localparam int B_INP = 11;

  // Decoder output indices
  localparam int D_AND = 0;
  localparam int D_ADD = 1;
  localparam int D_LDA = 2;
  localparam int D_IO  = 7;
  localparam int T_EXE = 3;
  localparam int T_MEM = 5;

  // AC op-select
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_AND = 4'd1,
    OP_ADD = 4'd2,
    OP_LDA = 4'd3,
    OP_CLR = 4'd4,
    OP_CMP = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_INC = 4'd8,
    OP_INP = 4'd9
  } ac_op_t;

  // E op-select; LSB/MSB capture the bit shifted out of AC by a rotate
  typedef enum logic [2:0] {
    E_HOLD  = 3'd0,
    E_CLR   = 3'd1,
    E_CMP   = 3'd2,
    E_CARRY = 3'd3,
    E_LSB   = 3'd4,
    E_MSB   = 3'd5
  } e_op_t;

endpackage
`default_nettype wire

// File: rtl/ac_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ac_ctrl
// Purpose  : Combinational AC/E control decode, skip and FGI-clear generation.
// Revision : 1.0  initial release
// ============================================================================
module ac_ctrl
  import ac_pkg::*;
(
  input  logic [7:0]  i_dec_t,
  input  logic [7:0]  i_dec_d,
  input  logic        i_iff,
  input  logic [11:0] i_ir,
  input  logic        i_ac_msb,
  input  logic        i_ac_zero,
  input  logic        i_e,
  output ac_op_t      o_ac_op,
  output e_op_t       o_e_op,
  output logic        o_skip,
  output logic        o_fgi_clr
);

  logic w_mem_and;
  logic w_mem_add;
  logic w_mem_lda;
  logic w_mem;
  logic w_r;
  logic w_p;
  logic w_unused;

  assign w_mem_and = i_dec_d[D_AND] & i_dec_t[T_MEM];
  assign w_mem_add = i_dec_d[D_ADD] & i_dec_t[T_MEM];
  assign w_mem_lda = i_dec_d[D_LDA] & i_dec_t[T_MEM];
  assign w_mem     = w_mem_and | w_mem_add | w_mem_lda;
  assign w_r       = i_dec_d[D_IO] & ~i_iff & i_dec_t[T_EXE];
  assign w_p       = i_dec_d[D_IO] &  i_iff & i_dec_t[T_EXE];

  // Decoder lines and IR bits that this unit does not act on
  assign w_unused = ^{i_dec_t[7:6], i_dec_t[4], i_dec_t[2:0], i_dec_d[6:3], i_ir[0]};

  // Priority decode: memory-reference first, then register-reference, then I/O
  always_comb begin
    o_ac_op   = OP_NOP;
    o_e_op    = E_HOLD;
    o_skip    = 1'b0;
    o_fgi_clr = 1'b0;
    if (w_mem) begin
      if (w_mem_and)      o_ac_op = OP_AND;
      else if (w_mem_add) begin
        o_ac_op = OP_ADD;
        o_e_op  = E_CARRY;
      end
      else                o_ac_op = OP_LDA;
    end
    else if (w_r) begin
      if (i_ir[B_CLA])      o_ac_op = OP_CLR;
      else if (i_ir[B_CMA]) o_ac_op = OP_CMP;
      else if (i_ir[B_CIR]) o_ac_op = OP_SHR;
      else if (i_ir[B_CIL]) o_ac_op = OP_SHL;
      else if (i_ir[B_INC]) o_ac_op = OP_INC;

      // E follows its own priority; a rotate still drives E if CLE/CME absent
      if (i_ir[B_CLE])      o_e_op = E_CLR;
      else if (i_ir[B_CME]) o_e_op = E_CMP;
      else if (i_ir[B_CIR]) o_e_op = E_LSB;
      else if (i_ir[B_CIL]) o_e_op = E_MSB;

      o_skip = (i_ir[B_SPA] & ~i_ac_msb) |
               (i_ir[B_SNA] &  i_ac_msb) |
               (i_ir[B_SZA] &  i_ac_zero) |
               (i_ir[B_SZE] & ~i_e);
    end
    else if (w_p) begin
      if (i_ir[B_INP]) begin
        o_ac_op   = OP_INP;
        o_fgi_clr = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ac_unit.sv
`default_nettype none
// ============================================================================
// Module   : ac_unit
// Purpose  : Accumulator unit: AC/E registers, ALU and control decode.
//            Optional signed-overflow flag enabled by macro AC_OVF_EN.
// Revision : 1.0  initial release
// ============================================================================
module ac_unit
  import ac_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int IN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        dec_t,
  input  logic [7:0]        dec_d,
  input  logic              iff_data,
  input  logic [11:0]       ir_data,
  input  logic [WORD_W-1:0] dr_data,
  input  logic [IN_W-1:0]   inpr_data,
  output logic [WORD_W-1:0] ac_q,
  output logic              e_q,
  output logic              skip,
  output logic              fgi_clr,
  output logic              ac_ovf
);

  logic [WORD_W-1:0] r_ac;
  logic              r_e;
  ac_op_t            w_ac_op;
  e_op_t             w_e_op;
  logic [WORD_W:0]   w_sum;
  logic [WORD_W-1:0] w_inp;
  logic [WORD_W-1:0] w_ac_next;
  logic              w_e_next;

  ac_ctrl u_ctrl (
    .i_dec_t   (dec_t),
    .i_dec_d   (dec_d),
    .i_iff     (iff_data),
    .i_ir      (ir_data),
    .i_ac_msb  (r_ac[WORD_W-1]),
    .i_ac_zero (r_ac == '0),
    .i_e       (r_e),
    .o_ac_op   (w_ac_op),
    .o_e_op    (w_e_op),
    .o_skip    (skip),
    .o_fgi_clr (fgi_clr)
  );

  assign w_sum = {1'b0, r_ac} + {1'b0, dr_data};

  // INP replaces only the low IN_W bits of AC
  always_comb begin
    w_inp             = r_ac;
    w_inp[IN_W-1:0]   = inpr_data;
  end

  // ALU: next AC value for the selected op
  always_comb begin
    w_ac_next = r_ac;
    case (w_ac_op)
      OP_AND:  w_ac_next = r_ac & dr_data;
      OP_ADD:  w_ac_next = w_sum[WORD_W-1:0];
      OP_LDA:  w_ac_next = dr_data;
      OP_CLR:  w_ac_next = '0;
      OP_CMP:  w_ac_next = ~r_ac;
      OP_SHR:  w_ac_next = {r_e, r_ac[WORD_W-1:1]};
      OP_SHL:  w_ac_next = {r_ac[WORD_W-2:0], r_e};
      OP_INC:  w_ac_next = r_ac + 1'b1;
      OP_INP:  w_ac_next = w_inp;
      default: w_ac_next = r_ac;
    endcase
  end

  // Next E value for the selected E op
  always_comb begin
    w_e_next = r_e;
    case (w_e_op)
      E_CLR:   w_e_next = 1'b0;
      E_CMP:   w_e_next = ~r_e;
      E_CARRY: w_e_next = w_sum[WORD_W];
      E_LSB:   w_e_next = r_ac[0];
      E_MSB:   w_e_next = r_ac[WORD_W-1];
      default: w_e_next = r_e;
    endcase
  end

  // AC and E registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac <= '0;
      r_e  <= 1'b0;
    end else begin
      r_ac <= w_ac_next;
      r_e  <= w_e_next;
    end
  end

  assign ac_q = r_ac;
  assign e_q  = r_e;

`ifdef AC_OVF_EN
  logic r_ovf;
  logic w_add_ovf;

  // Operands share a sign but the sum's sign differs
  assign w_add_ovf = (r_ac[WORD_W-1] == dr_data[WORD_W-1]) &&
                     (w_sum[WORD_W-1] != r_ac[WORD_W-1]);

  // Sticky overflow flag: set by an overflowing ADD, cleared by CLA or LDA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ac_op == OP_CLR || w_ac_op == OP_LDA) begin
      r_ovf <= 1'b0;
    end else if (w_ac_op == OP_ADD && w_add_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ac_ovf = r_ovf;
`else
  assign ac_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ac_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_unit
// Purpose  : Self-checking bench for ac_unit (WORD_W=16, IN_W=8): directed
//            vector table, reset corner cases and a randomized run against a
//            behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ac_unit;

`ifdef AC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  dec_t = '0;
  logic [7:0]  dec_d = '0;
  logic        iff_data = 1'b0;
  logic [11:0] ir_data = '0;
  logic [15:0] dr_data = '0;
  logic [7:0]  inpr_data = '0;
  logic [15:0] ac_q;
  logic        e_q;
  logic        skip;
  logic        fgi_clr;
  logic        ac_ovf;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  int m_ac  = 0;
  int m_e   = 0;
  int m_ovf = 0;

  ac_unit #(.WORD_W(16), .IN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .dec_t     (dec_t),
    .dec_d     (dec_d),
    .iff_data  (iff_data),
    .ir_data   (ir_data),
    .dr_data   (dr_data),
    .inpr_data (inpr_data),
    .ac_q      (ac_q),
    .e_q       (e_q),
    .skip      (skip),
    .fgi_clr   (fgi_clr),
    .ac_ovf    (ac_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;     // timing index 0..7, 8 = no T line
    int          d;     // opcode index 0..7
    bit          i;
    logic [11:0] ir;
    logic [15:0] dr;
    logic [7:0]  inpr;
    logic [15:0] ac;    // expected after the edge
    bit          e;
    bit          skp;   // expected during the strobe cycle
    bit          fgi;
    bit          ovf;   // expected when the overflow flag is built in
  } vec_t;

  vec_t tbl[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs on the falling edge
  task automatic drive(input int t, input int d, input bit i, input logic [11:0] ir,
                       input logic [15:0] dr, input logic [7:0] inpr);
    @(negedge clk);
    dec_t     = (t < 8) ? (8'd1 << t) : 8'd0;
    dec_d     = 8'd1 << d;
    iff_data  = i;
    ir_data   = ir;
    dr_data   = dr;
    inpr_data = inpr;
    #1;
  endtask

  // Behavioural model: apply one cycle's rules, return comb expectations
  task automatic model_step(input int t, input int d, input bit i, input int ir,
                            input int dr, input int inpr,
                            output int exp_skip, output int exp_fgi);
    int ac, e, sa, sd, ss;
    bit mem, r, p;
    ac = m_ac; e = m_e;
    mem = (t == 5) && (d <= 2);
    r   = (t == 3) && (d == 7) && !i;
    p   = (t == 3) && (d == 7) && i;
    exp_skip = 0; exp_fgi = 0;
    if (mem) begin
      if (d == 0) m_ac = ac & dr;
      else if (d == 1) begin
        m_ac = (ac + dr) % 65536;
        m_e  = (ac + dr) / 65536;
        sa = (ac >= 32768) ? ac - 65536 : ac;
        sd = (dr >= 32768) ? dr - 65536 : dr;
        ss = sa + sd;
        if (OVF_ON && (ss > 32767 || ss < -32768)) m_ovf = 1;
      end else begin
        m_ac = dr;
        m_ovf = 0;
      end
    end else if (r) begin
      exp_skip = ((ir[4] && ac < 32768) || (ir[3] && ac >= 32768) ||
                  (ir[2] && ac == 0) || (ir[1] && e == 0)) ? 1 : 0;
      if (ir[11]) begin m_ac = 0; m_ovf = 0; end
      else if (ir[9]) m_ac = 65535 - ac;
      else if (ir[7]) m_ac = e * 32768 + ac / 2;
      else if (ir[6]) m_ac = (ac * 2) % 65536 + e;
      else if (ir[5]) m_ac = (ac + 1) % 65536;
      if (ir[10]) m_e = 0;
      else if (ir[8]) m_e = 1 - e;
      else if (ir[7]) m_e = ac % 2;
      else if (ir[6]) m_e = ac / 32768;
    end else if (p) begin
      if (ir[11]) begin
        m_ac = (ac / 256) * 256 + inpr;
        exp_fgi = 1;
      end
    end
  endtask

  initial begin
    int es, ef, kind, t, d, ir, dr, inpr;
    bit i;

    // t  d  i  ir       dr        inpr   ac        e  skp fgi ovf
    tbl[0]  = '{5, 2, 1'b0, 12'h000, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0}; // LDA
    tbl[1]  = '{5, 1, 1'b0, 12'h000, 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD carry
    tbl[2]  = '{5, 2, 1'b0, 12'h000, 16'h8001, 8'h00, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3, 7, 1'b0, 12'h400, 16'h0000, 8'h00, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0}; // CLE
    tbl[4]  = '{3, 7, 1'b0, 12'h040, 16'h0000, 8'h00, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}; // CIL
    tbl[5]  = '{3, 7, 1'b0, 12'h080, 16'h0000, 8'h00, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0}; // CIR
    tbl[6]  = '{5, 2, 1'b0, 12'h000, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3, 7, 1'b0, 12'h020, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}; // INC wrap
    tbl[8]  = '{3, 7, 1'b0, 12'h004, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}; // SZA
    tbl[9]  = '{5, 2, 1'b0, 12'h000, 16'hAB00, 8'h00, 16'hAB00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3, 7, 1'b1, 12'h800, 16'h0000, 8'h5C, 16'hAB5C, 1'b0, 1'b0, 1'b1, 1'b0}; // INP
    tbl[11] = '{5, 2, 1'b0, 12'h000, 16'h00F0, 8'h00, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3, 7, 1'b0, 12'h100, 16'h0000, 8'h00, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b0}; // CME
    tbl[13] = '{3, 7, 1'b0, 12'h600, 16'h0000, 8'h00, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0}; // CLE+CMA
    tbl[14] = '{8, 7, 1'b0, 12'hFFF, 16'h1234, 8'hEE, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0}; // hold
    tbl[15] = '{8, 1, 1'b0, 12'hFFF, 16'h1234, 8'hEE, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{8, 7, 1'b1, 12'hFFF, 16'h1234, 8'hEE, 16'hFF0F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{5, 2, 1'b0, 12'h000, 16'h7FFF, 8'h00, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{5, 1, 1'b0, 12'h000, 16'h0001, 8'h00, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1}; // ADD ovf
    tbl[19] = '{3, 7, 1'b0, 12'h018, 16'h0000, 8'h00, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}; // SPA|SNA
    tbl[20] = '{3, 7, 1'b0, 12'h010, 16'h0000, 8'h00, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1}; // SPA
    tbl[21] = '{3, 7, 1'b0, 12'h002, 16'h0000, 8'h00, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}; // SZE
    tbl[22] = '{5, 0, 1'b0, 12'h000, 16'h0F0F, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}; // AND
    tbl[23] = '{3, 7, 1'b1, 12'h7FF, 16'h0000, 8'h33, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}; // p, no INP
    tbl[24] = '{3, 7, 1'b0, 12'h800, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}; // CLA
    tbl[25] = '{3, 1, 1'b0, 12'hFFF, 16'hFFFF, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}; // D1 at T3

    // Asynchronous reset at start, no clock edge required
    #1 rst = 1'b1;
    #1;
    check("reset ac", ac_q, 16'h0000);
    check("reset e", e_q, 1'b0);
    check("reset ovf", ac_ovf, 1'b0);
    check("reset skip", skip, 1'b0);
    check("reset fgi", fgi_clr, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].t, tbl[k].d, tbl[k].i, tbl[k].ir, tbl[k].dr, tbl[k].inpr);
      check($sformatf("vec%0d skip", k), skip, tbl[k].skp);
      check($sformatf("vec%0d fgi_clr", k), fgi_clr, tbl[k].fgi);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ac", k), ac_q, tbl[k].ac);
      check($sformatf("vec%0d e", k), e_q, tbl[k].e);
      check($sformatf("vec%0d ovf", k), ac_ovf, OVF_ON ? tbl[k].ovf : 1'b0);
    end

    // Mid-cycle asynchronous reset with AC loaded
    drive(5, 2, 1'b0, 12'h000, 16'h1234, 8'h00);
    @(posedge clk);
    #1;
    check("preload ac", ac_q, 16'h1234);
    drive(3, 7, 1'b0, 12'h100, 16'h0000, 8'h00); // CME pending when reset arrives
    rst = 1'b1;
    #1;
    check("midreset ac", ac_q, 16'h0000);
    check("midreset e", e_q, 1'b0);
    @(posedge clk);
    #1;
    dec_t = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post reset ac", ac_q, 16'h0000);
    check("post reset e", e_q, 1'b0);
    m_ac = 0; m_e = 0; m_ovf = 0;

    // Randomized run against the behavioural model
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      ir   = $urandom_range(0, 4095);
      dr   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h0001)
                                         : $urandom_range(0, 65535);
      inpr = $urandom_range(0, 255);
      i    = 1'b0;
      if (kind <= 3) begin
        t = 5; d = $urandom_range(0, 2);
      end else if (kind <= 6) begin
        t = 3; d = 7;
      end else if (kind == 7) begin
        t = 3; d = 7; i = 1'b1;
      end else begin
        t = $urandom_range(0, 8);
        d = $urandom_range(0, 7);
        i = 1'($urandom_range(0, 1));
        if (t == 3 && d == 7) t = 6;
      end
      drive(t, d, i, 12'(ir), 16'(dr), 8'(inpr));
      model_step(t, d, i, ir, dr, inpr, es, ef);
      check($sformatf("rnd%0d skip", n), skip, es);
      check($sformatf("rnd%0d fgi_clr", n), fgi_clr, ef);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d ac", n), ac_q, m_ac);
      check($sformatf("rnd%0d e", n), e_q, m_e);
      check($sformatf("rnd%0d ovf", n), ac_ovf, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
